// File: rtl/dco_tdc_pkg.sv
`timescale 1fs/1fs
// Shared widths, default DCO constants and the TDC phase arithmetic for the
// DCO/TDC behavioural front end. Time is counted in femtoseconds.
package dco_tdc_pkg;
  localparam int L_W   = 5;
  localparam int MS_W  = 16;
  localparam int L_CW  = 5;
  localparam int MS_CW = 9;
  localparam int RC_W  = 7;
  localparam int PH_W  = 16;
  localparam int PER_W = 32;

  localparam int unsigned P0_FS_DEF = 380000;
  localparam int unsigned KL_FS_DEF = 2000;
  localparam int unsigned KM_FS_DEF = 50;
  localparam int unsigned KS_FS_DEF = 1;

  // Fraction of a ckv period since the last rising edge, saturated to
  // 16 bits, with the (7 - freq) LSBs cleared.
  function automatic logic [PH_W-1:0] phase_calc(input longint unsigned dt,
                                                 input logic [PER_W-1:0] p,
                                                 input logic [2:0] freq);
    longint unsigned q;
    logic [PH_W-1:0] mask;
    q    = (dt << 16) / 64'(p);
    mask = 16'hFFFF << (3'd7 - freq);
    return (q > 64'd65535) ? mask : (q[PH_W-1:0] & mask);
  endfunction
endpackage

// File: rtl/dco_tdc_if.sv
`timescale 1fs/1fs
// Control/observation bundle between the ADPLL loop and the DCO/TDC model.
interface dco_tdc_if;
  import dco_tdc_pkg::*;
  logic                dco_pd;
  logic [1:0]          dco_osc_gain;
  logic [L_W-1:0]      dco_c_l_rall, dco_c_l_row, dco_c_l_col;
  logic [MS_W-1:0]     dco_c_m_rall, dco_c_m_row, dco_c_m_col;
  logic [MS_W-1:0]     dco_c_s_rall, dco_c_s_row, dco_c_s_col;
  logic                dco_ckv;
  logic [PER_W-1:0]    dco_period_fs;
  logic [MS_CW-1:0]    dco_c_s_val_sum;
  logic                tdc_pd;
  logic                tdc_pd_inj;
  logic [2:0]          tdc_ctr_freq;
  logic [RC_W-1:0]     tdc_ripple_count;
  logic [PH_W-1:0]     tdc_phase;

  modport master (
    output dco_pd, dco_osc_gain,
           dco_c_l_rall, dco_c_l_row, dco_c_l_col,
           dco_c_m_rall, dco_c_m_row, dco_c_m_col,
           dco_c_s_rall, dco_c_s_row, dco_c_s_col,
           tdc_pd, tdc_pd_inj, tdc_ctr_freq,
    input  dco_ckv, dco_period_fs, dco_c_s_val_sum, tdc_ripple_count, tdc_phase
  );
  modport slave (
    input  dco_pd, dco_osc_gain,
           dco_c_l_rall, dco_c_l_row, dco_c_l_col,
           dco_c_m_rall, dco_c_m_row, dco_c_m_col,
           dco_c_s_rall, dco_c_s_row, dco_c_s_col,
           tdc_pd, tdc_pd_inj, tdc_ctr_freq,
    output dco_ckv, dco_period_fs, dco_c_s_val_sum, tdc_ripple_count, tdc_phase
  );
endinterface

// File: rtl/dco_tdc_model_decode.sv
`timescale 1fs/1fs
// Thermometer-matrix capacitor bank: whole rows (rall) count W units each,
// partially enabled rows count one unit per enabled column.
module cap_bank_decode #(
  parameter int W  = 16,
  parameter int CW = 9
) (
  input  logic [W-1:0]  rall,
  input  logic [W-1:0]  row,
  input  logic [W-1:0]  col,
  output logic [CW-1:0] units
);
  assign units = CW'(W * $countones(rall) + $countones(row & ~rall) * $countones(col));
endmodule

// File: rtl/dco_tdc_model.sv
`timescale 1fs/1fs
// DCO with capacitor-bank controlled period, sampled by a TDC on clk.
// Oscillator edges are timed events; the TDC is a plain clk register stage.
module dco_tdc_model
  import dco_tdc_pkg::*;
#(
  parameter int unsigned P0_FS = P0_FS_DEF,
  parameter int unsigned KL_FS = KL_FS_DEF,
  parameter int unsigned KM_FS = KM_FS_DEF,
  parameter int unsigned KS_FS = KS_FS_DEF
) (
  input logic     clk,
  input logic     rst,
  dco_tdc_if.slave bus
);
  logic [L_CW-1:0]  l_units;
  logic [MS_CW-1:0] m_units, s_units;
  logic [PER_W-1:0] p_comb;
  logic             stopped;

  cap_bank_decode #(.W(L_W),  .CW(L_CW))  u_dec_l (.rall(bus.dco_c_l_rall), .row(bus.dco_c_l_row),
                                                   .col(bus.dco_c_l_col), .units(l_units));
  cap_bank_decode #(.W(MS_W), .CW(MS_CW)) u_dec_m (.rall(bus.dco_c_m_rall), .row(bus.dco_c_m_row),
                                                   .col(bus.dco_c_m_col), .units(m_units));
  cap_bank_decode #(.W(MS_W), .CW(MS_CW)) u_dec_s (.rall(bus.dco_c_s_rall), .row(bus.dco_c_s_row),
                                                   .col(bus.dco_c_s_col), .units(s_units));

  assign p_comb  = P0_FS + KL_FS * 32'(l_units) + KM_FS * 32'(m_units) + KS_FS * 32'(s_units);
  assign stopped = bus.dco_pd | (bus.dco_osc_gain == 2'd0) | rst;

  logic             ckv_q;
  logic [PER_W-1:0] per_q;
  logic [RC_W-1:0]  edge_cnt;
  longint unsigned  t_last, t_rise_next;
  int unsigned      epoch;

  // One oscillator thread per start; a thread whose epoch is stale has been
  // superseded by a stop and exits without touching the outputs.
  task automatic osc_run(input int unsigned e);
    logic [PER_W-1:0] p, h;
    p           = (p_comb < 32'd2) ? 32'd2 : p_comb;
    per_q       = p;
    t_rise_next = $time + 64'(p / 2);
    #(p / 2);
    while (e == epoch) begin
      p           = (p_comb < 32'd2) ? 32'd2 : p_comb;
      h           = p / 2;
      per_q       = p;
      ckv_q       = 1'b1;
      t_last      = $time;
      t_rise_next = $time + 64'(p);
      if (!bus.tdc_pd) edge_cnt = edge_cnt + 7'd1;
      #(h);
      if (e != epoch) return;
      ckv_q = 1'b0;
      #(p - h);
    end
  endtask

  always @(stopped or rst) begin
    epoch = epoch + 1;
    ckv_q = 1'b0;
    if (rst) begin
      edge_cnt = '0;
      t_last   = '0;
    end
    if (!stopped) fork osc_run(epoch); join_none
  end

  assign bus.dco_ckv         = ckv_q & ~stopped;
  assign bus.dco_period_fs   = stopped ? '0 : per_q;
  assign bus.dco_c_s_val_sum = s_units;

  logic [RC_W-1:0] rc_q;
  logic [PH_W-1:0] ph_q;

  // A ckv edge due at this very instant belongs before the clk edge, even if
  // its thread has not been scheduled yet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc_q <= '0;
      ph_q <= '0;
    end else if (bus.tdc_pd) begin
      rc_q <= '0;
      ph_q <= '0;
    end else begin
      rc_q <= (!stopped && t_rise_next == $time) ? edge_cnt + 7'd1 : edge_cnt;
      if (stopped || per_q == '0 || bus.tdc_pd_inj || t_rise_next == $time)
        ph_q <= '0;
      else
        ph_q <= phase_calc($time - t_last, per_q, bus.tdc_ctr_freq);
    end
  end

  assign bus.tdc_ripple_count = rc_q;
  assign bus.tdc_phase        = ph_q;
endmodule

// File: tb/tb_dco_tdc_model.sv
`timescale 1fs/1fs
// Directed and randomized checks of the DCO/TDC model against an analytic
// edge-time reference (edges at t0 + P/2 + n*P after each restart).
module tb_dco_tdc_model;
  localparam longint unsigned CLK_T = 40_000_000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dco_tdc_if bus();
  dco_tdc_model dut (.clk(clk), .rst(rst), .bus(bus));

  always #(CLK_T / 2) clk = ~clk;

  initial begin
    #(64'd10_000_000_000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ckv(input string tag, input bit lvl, output longint unsigned t);
    if (lvl) fork wait (bus.dco_ckv === 1'b1); #(2_000_000); join_any
    else     fork wait (bus.dco_ckv === 1'b0); #(2_000_000); join_any
    t = $time;
    chk({tag, "_lvl"}, longint'(bus.dco_ckv), longint'(lvl));
  endtask

  function automatic longint unsigned units(input int w, input logic [15:0] rall,
                                            input logic [15:0] row, input logic [15:0] col);
    return longint'(w * $countones(rall) + $countones(row & ~rall) * $countones(col));
  endfunction

  function automatic longint unsigned model_period();
    return 380000
         + 2000 * units(5,  16'(bus.dco_c_l_rall), 16'(bus.dco_c_l_row), 16'(bus.dco_c_l_col))
         + 50   * units(16, bus.dco_c_m_rall, bus.dco_c_m_row, bus.dco_c_m_col)
         +        units(16, bus.dco_c_s_rall, bus.dco_c_s_row, bus.dco_c_s_col);
  endfunction

  function automatic void model_tdc(input longint unsigned t, input longint unsigned t0,
                                    input longint unsigned p, input logic [2:0] f, input bit inj,
                                    output longint rc, output longint ph);
    longint unsigned n, tl, q;
    if (t < t0 + p / 2) begin n = 0; tl = 0; end
    else begin
      n  = (t - t0 - p / 2) / p + 1;
      tl = t0 + p / 2 + (n - 1) * p;
    end
    rc = longint'(n % 128);
    q  = ((t - tl) * 65536) / p;
    if (q > 65535) q = 65535;
    q  = (q >> (7 - f)) << (7 - f);
    ph = inj ? 0 : longint'(q);
  endfunction

  task automatic clear_codes();
    bus.dco_c_l_rall = '0; bus.dco_c_l_row = '0; bus.dco_c_l_col = '0;
    bus.dco_c_m_rall = '0; bus.dco_c_m_row = '0; bus.dco_c_m_col = '0;
    bus.dco_c_s_rall = '0; bus.dco_c_s_row = '0; bus.dco_c_s_col = '0;
  endtask

  // Release reset so the first ckv rise lands `lead` fs before a clk edge.
  task automatic phase_case(input string tag, input longint unsigned lead, input logic [2:0] f,
                            input bit inj, input longint rc_exp, input longint ph_exp);
    rst = 1'b1;
    bus.tdc_ctr_freq = f;
    bus.tdc_pd_inj   = inj;
    @(posedge clk);
    #(CLK_T - 190_000 - lead);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_rc"}, longint'(bus.tdc_ripple_count), rc_exp);
    chk({tag, "_ph"}, longint'(bus.tdc_phase), ph_exp);
  endtask

  initial begin
    longint unsigned t0, t1, t2, t3, t4, t5, te, p_exp;
    longint rc, ph;

    bus.dco_pd = 1'b1; bus.dco_osc_gain = 2'd1;
    bus.tdc_pd = 1'b0; bus.tdc_pd_inj = 1'b0; bus.tdc_ctr_freq = 3'd7;
    clear_codes();

    #(100_000);
    chk("rst_ripple", longint'(bus.tdc_ripple_count), 0);
    chk("rst_phase",  longint'(bus.tdc_phase), 0);
    chk("rst_ckv",    longint'(bus.dco_ckv), 0);

    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #(250_000);
      chk("pd_ckv", longint'(bus.dco_ckv), 0);
    end
    chk("pd_period", longint'(bus.dco_period_fs), 0);

    // Free run from a power-down release.
    bus.dco_pd = 1'b0; t0 = $time;
    wait_ckv("fr_r1", 1'b1, t1);
    wait_ckv("fr_f1", 1'b0, t2);
    wait_ckv("fr_r2", 1'b1, t3);
    chk("fr_restart_low", longint'(t1 - t0), 190000);
    chk("fr_high",        longint'(t2 - t1), 190000);
    chk("fr_low",         longint'(t3 - t2), 190000);
    chk("fr_period",      longint'(bus.dco_period_fs), 380000);

    bus.dco_osc_gain = 2'd0; #(1000);
    chk("gain0_ckv",    longint'(bus.dco_ckv), 0);
    chk("gain0_period", longint'(bus.dco_period_fs), 0);
    bus.dco_osc_gain = 2'd1;

    bus.dco_c_s_rall = 16'h0003; bus.dco_c_s_row = 16'h0004; bus.dco_c_s_col = 16'h000F;
    #(800_000);
    chk("dec_s_sum",    longint'(bus.dco_c_s_val_sum), 36);
    chk("dec_s_period", longint'(bus.dco_period_fs), 380036);
    clear_codes(); bus.dco_c_l_rall = 5'h1F;
    #(900_000);
    chk("dec_l_period", longint'(bus.dco_period_fs), 430000);
    clear_codes();
    #(900_000);

    // Code change while ckv is high takes effect from the next rise.
    wait_ckv("mc_f0", 1'b0, t1);
    wait_ckv("mc_r0", 1'b1, t1);
    #(1000);
    bus.dco_c_m_rall = 16'h0001;
    wait_ckv("mc_f1", 1'b0, t2);
    wait_ckv("mc_r1", 1'b1, t3);
    wait_ckv("mc_f2", 1'b0, t4);
    wait_ckv("mc_r2", 1'b1, t5);
    chk("mc_old_high",   longint'(t2 - t1), 190000);
    chk("mc_old_period", longint'(t3 - t1), 380000);
    chk("mc_new_high",   longint'(t4 - t3), 190400);
    chk("mc_new_period", longint'(t5 - t3), 380800);
    chk("mc_period_out", longint'(bus.dco_period_fs), 380800);
    clear_codes();

    wait_ckv("rh_f", 1'b0, t1);
    wait_ckv("rh_r", 1'b1, t1);
    #(1000);
    rst = 1'b1;
    #1;
    chk("rst_mid_ckv",    longint'(bus.dco_ckv), 0);
    chk("rst_mid_period", longint'(bus.dco_period_fs), 0);

    phase_case("ph_f7",       95000, 3'd7, 1'b0, 1, 16384);
    phase_case("ph_f0",       95000, 3'd0, 1'b0, 1, 16384);
    phase_case("ph_inj",      95000, 3'd7, 1'b1, 1, 0);
    phase_case("ph_coinc",    0,     3'd7, 1'b0, 1, 0);
    phase_case("ph_small_f7", 1000,  3'd7, 1'b0, 1, 172);
    phase_case("ph_small_f3", 1000,  3'd3, 1'b0, 1, 160);

    bus.tdc_pd_inj = 1'b0; bus.tdc_pd = 1'b1;
    @(posedge clk); #1;
    chk("tdcpd_rc", longint'(bus.tdc_ripple_count), 0);
    chk("tdcpd_ph", longint'(bus.tdc_phase), 0);
    bus.tdc_pd = 1'b0;

    // Randomized restarts; segment 0 keeps all banks cleared.
    for (int s = 0; s < 8; s++) begin
      rst = 1'b1;
      clear_codes();
      if (s != 0) begin
        bus.dco_c_l_rall = 5'($urandom);  bus.dco_c_l_row = 5'($urandom);  bus.dco_c_l_col = 5'($urandom);
        bus.dco_c_m_rall = 16'($urandom); bus.dco_c_m_row = 16'($urandom); bus.dco_c_m_col = 16'($urandom);
        bus.dco_c_s_rall = 16'($urandom); bus.dco_c_s_row = 16'($urandom); bus.dco_c_s_col = 16'($urandom);
        bus.dco_osc_gain = 2'($urandom_range(1, 3));
      end
      p_exp = model_period();
      @(posedge clk);
      #($urandom_range(1_000_000, 39_000_000));
      rst = 1'b0; t0 = $time;
      #1;
      chk("rnd_period", longint'(bus.dco_period_fs), longint'(p_exp));
      chk("rnd_ssum", longint'(bus.dco_c_s_val_sum),
          longint'(units(16, bus.dco_c_s_rall, bus.dco_c_s_row, bus.dco_c_s_col)));
      for (int k = 0; k < 4; k++) begin
        bus.tdc_ctr_freq = 3'($urandom_range(0, 7));
        bus.tdc_pd_inj   = ($urandom_range(0, 3) == 0);
        @(posedge clk); te = $time; #1;
        model_tdc(te, t0, p_exp, bus.tdc_ctr_freq, bus.tdc_pd_inj, rc, ph);
        chk("rnd_ripple", longint'(bus.tdc_ripple_count), rc);
        chk("rnd_phase",  longint'(bus.tdc_phase), ph);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dco_tdc_model.md
Name: dco_tdc_model

Overview:
Behavioural model of the ADPLL analog front end. It combines a digitally controlled oscillator (DCO), whose period is set by three thermometer-matrix capacitor banks, with a time-to-digital converter (TDC). The TDC samples the DCO output on the reference clock. It sits under the ADPLL bench in place of the analog macro and feeds the digital loop filter. Time unit is 1 fs.

Parameters:
P0_FS, 380000, DCO period in fs with all capacitor banks cleared.
KL_FS, 2000, period increment per large-bank unit (fs).
KM_FS, 50, period increment per medium-bank unit (fs).
KS_FS, 1, period increment per small-bank unit (fs).

Ports:
clk  in  1  TDC reference clock; sampling on rising edge.
rst  in  1  asynchronous, active-high reset.
dco_pd  in  1  DCO power-down.
dco_osc_gain  in  2  oscillator gain; 0 = no oscillation.
dco_c_l_rall / dco_c_l_row / dco_c_l_col  in  5 each  large bank, 5x5 matrix.
dco_c_m_rall / dco_c_m_row / dco_c_m_col  in  16 each  medium bank, 16x16 matrix.
dco_c_s_rall / dco_c_s_row / dco_c_s_col  in  16 each  small bank, 16x16 matrix.
dco_ckv  out  1  DCO clock.
dco_period_fs  out  32  current DCO period in fs; 0 when stopped.
dco_c_s_val_sum  out  9  small-bank unit count (debug/logging).
tdc_pd  in  1  TDC power-down.
tdc_pd_inj  in  1  phase-injection power-down.
tdc_ctr_freq  in  3  phase resolution select.
tdc_ripple_count  out  7  ckv rising-edge counter sampled at clk.
tdc_phase  out  16  fractional ckv phase at clk.

Behaviour:
- Bank decode, W = bank width:
  - units = W*popcount(rall) + popcount(row & ~rall)*popcount(col).
  - Large bank: 0..25 units. Medium and small banks: 0..256 units.
  - Decode is combinational; dco_c_s_val_sum = small-bank units.
- Period: P0_FS + KL_FS*L + KM_FS*M + KS_FS*S, unsigned 32-bit.
- Stopped condition: dco_pd=1, or dco_osc_gain==0, or rst=1.
  - Stopped: dco_ckv=0 and dco_period_fs=0.
  - The oscillator restarts with a low phase of P/2 after the stop condition clears.
- Running:
  - high time = floor(P/2); low time = P - floor(P/2).
  - P is latched at each ckv rising edge, so code changes mid-cycle take effect at the next rising edge.
- TDC internal state: 7-bit edge counter incremented on every ckv rising edge, wrapping 127->0. Time of the last ckv rising edge is stored as t_last.
- At each clk rising edge:
  - tdc_ripple_count <= edge counter.
  - tdc_phase <= min(65535, floor((t_now - t_last)*65536 / P_latched)).
  - The low (7 - tdc_ctr_freq) bits of the phase are zeroed (tdc_ctr_freq=7 gives full resolution).
  - An edge coinciding with the clk edge counts as before the clk edge: counted, and phase = 0.
- tdc_pd_inj=1: tdc_phase <= 0; the ripple count is still updated.
- tdc_pd=1: both TDC outputs <= 0 at the clk edge; the edge counter is held.
- DCO stopped or P_latched=0: phase <= 0.
- Reset (async): tdc_ripple_count=0, tdc_phase=0, edge counter=0, t_last=0, dco_ckv=0. Reset applies immediately, mid-cycle included.
- Latency: outputs are valid after the clk edge that sampled them (one-register latency).

Decomposition:
- Package dco_tdc_pkg:
  - bank widths (5, 16) and count widths (5, 9);
  - output widths (7, 16, 32);
  - default P0/K constants.
- Sub-module cap_bank_decode, parameterised by W: rall/row/col in, unit count out. Instantiated three times.

Test Plan:
- Reset and power-down: rst=1 -> all TDC outputs 0, dco_ckv=0. rst=0 with dco_pd=1 -> ckv stays 0, dco_period_fs=0.
- Free run, all banks 0, gain=1: dco_period_fs=380000; ckv high 190000 fs, low 190000 fs.
- Bank decode:
  - c_s_rall=16'h0003, row=16'h0004, col=16'h000F -> c_s_val_sum=36, period 380036.
  - c_l_rall=5'h1F -> period 430000.
- Ripple count: clk period 40,000,000 fs, banks 0 -> tdc_ripple_count advances by 105 or 106 mod 128 each clk (long-run average 105.26).
- Phase: clk edge 95000 fs after a ckv rising edge with P=380000, ctr_freq=7 -> phase=16384. With ctr_freq=0 -> phase=16384 (low 7 bits zero). With tdc_pd_inj=1 -> phase=0.
- Mid-cycle code change: change c_m while ckv is high -> current period unchanged; the next period reflects the new code. Assert rst mid-high -> ckv drops to 0 immediately.
